data_mem_responder: RTL and testbench

Data-memory responder at the far end of the load/store control path produced by the main decoder. It accepts one load or store request at a time and performs RV32I byte, halfword or word access on a little-endian byte array. Loads are sign- or zero-extended. The block has a configurable read latency and raises a stall to the pipeline while an access is outstanding.

---
 rtl/data_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : RV32I load/store responder on a little-endian byte array with
//            configurable read latency, sign/zero extension and a pipeline
//            stall. Optional macro MISALIGN_TRAP_EN turns misaligned accesses
//            into error responses; otherwise they are forced to alignment.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  // Counter preload for BUSY; BUSY is skipped entirely when RD_LATENCY is 1.
  localparam logic [2:0] c_lat_m2 = 3'((RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0);

  localparam logic [ADDR_WIDTH-1:0] c_one = ADDR_WIDTH'(1);

  logic [7:0]            r_mem [0:(2**ADDR_WIDTH)-1];
  logic [1:0]            r_state;
  logic [2:0]            r_cnt;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_bad;
  logic                  r_mis;
  logic [31:0]           r_rdata;

  logic                  w_accept;
  logic                  w_req_bad;
  logic                  w_req_mis;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_we;
  logic                  w_use_req;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [2:0]            w_sel_f3;
  logic                  w_sel_bad;
  logic                  w_sel_mis;
  logic [7:0]            w_b0, w_b1, w_b2, w_b3;
  logic [31:0]           w_ld;
  logic [31:0]           w_rd_next;
  logic                  w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH];

  assign req_ready  = (r_state == c_st_idle);
  assign resp_valid = (r_state == c_st_resp);
  assign resp_err   = (r_state == c_st_resp) && (r_bad || r_mis);
  assign resp_rdata = r_rdata;
  assign stall      = ((r_state == c_st_idle) && req_valid) || (r_state == c_st_busy);
  assign w_accept   = req_valid && req_ready;

  // Decode the incoming request: unsupported size, misalignment, aligned index.
  always_comb begin
    w_req_bad  = req_write ? (req_funct3 >= 3'd3)
                           : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    w_req_addr = req_addr[ADDR_WIDTH-1:0];
    if (req_funct3[1:0] == 2'b01) begin
      w_req_addr[0] = 1'b0;
    end else if (req_funct3[1:0] == 2'b10) begin
      w_req_addr[1:0] = 2'b00;
    end
`ifdef MISALIGN_TRAP_EN
    w_req_mis = !w_req_bad &&
                (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
    w_req_mis = 1'b0;
`endif
    w_we = w_accept && req_write && !w_req_bad && !w_req_mis && !rst;
  end

  // Read path: single-cycle loads read from the live request, others from the captured one.
  always_comb begin
    w_use_req  = (r_state == c_st_idle);
    w_sel_addr = w_use_req ? w_req_addr : r_addr;
    w_sel_f3   = w_use_req ? req_funct3 : r_funct3;
    w_sel_bad  = w_use_req ? w_req_bad  : r_bad;
    w_sel_mis  = w_use_req ? w_req_mis  : r_mis;
    w_b0 = r_mem[w_sel_addr];
    w_b1 = r_mem[w_sel_addr + c_one];
    w_b2 = r_mem[w_sel_addr + (c_one << 1)];
    w_b3 = r_mem[w_sel_addr + (c_one << 1) + c_one];
    case (w_sel_f3)
      3'b000:  w_ld = {{24{w_b0[7]}}, w_b0};
      3'b001:  w_ld = {{16{w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_ld = {w_b3, w_b2, w_b1, w_b0};
      3'b100:  w_ld = {24'd0, w_b0};
      3'b101:  w_ld = {16'd0, w_b1, w_b0};
      default: w_ld = 32'd0;
    endcase
    if (w_sel_bad) begin
      w_rd_next = 32'd0;
    end else if (w_sel_mis) begin
      w_rd_next = r_rdata;
    end else begin
      w_rd_next = w_ld;
    end
  end

  // Store bytes land at the acceptance edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_req_addr] <= req_wdata[7:0];
      if (req_funct3[1:0] != 2'b00) begin
        r_mem[w_req_addr + c_one] <= req_wdata[15:8];
      end
      if (req_funct3[1:0] == 2'b10) begin
        r_mem[w_req_addr + (c_one << 1)]         <= req_wdata[23:16];
        r_mem[w_req_addr + (c_one << 1) + c_one] <= req_wdata[31:24];
      end
    end
  end

  // Request capture, latency counting and response sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_cnt    <= 3'd0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_bad    <= 1'b0;
      r_mis    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_funct3 <= req_funct3;
            r_addr   <= w_req_addr;
            r_bad    <= w_req_bad;
            r_mis    <= w_req_mis;
            if (req_write) begin
              r_state <= c_st_resp;
            end else if (RD_LATENCY == 1) begin
              r_state <= c_st_resp;
              r_rdata <= w_rd_next;
            end else begin
              r_state <= c_st_busy;
              r_cnt   <= c_lat_m2;
            end
          end
        end
        c_st_busy: begin
          if (r_cnt == 3'd0) begin
            r_state <= c_st_resp;
            r_rdata <= w_rd_next;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Scoreboard bench for data_mem_responder (ADDR_WIDTH=17,
//            RD_LATENCY=2); expectations follow MISALIGN_TRAP_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  data_mem_responder #(.ADDR_WIDTH(17), .RD_LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Edge counter used to time responses against acceptance.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard and compares data, error, timing.
  always @(negedge clk) begin : mon
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, resp_rdata, e.rd);
        check({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        check({e.tag, "_lat"}, cyc, e.cyc);
        check({e.tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
      end
    end
  end

  // Drive one request at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.cyc = cyc + lat - 1;
    e.tag = tag;
    sb.push_back(e);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    @(negedge clk);
    check({tag, "_stall_wait"}, {31'd0, stall}, {31'd0, (lat > 1)});
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store/load and extension variants.
    do_req("sw100",  1'b1, 3'b010, 32'h0000_0100, 32'h8000_00FF, 32'h0000_0000, 1'b0, 1);
    do_req("lw100",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h8000_00FF, 1'b0, 2);
    do_req("lb100",  1'b0, 3'b000, 32'h0000_0100, 32'h0,         32'hFFFF_FFFF, 1'b0, 2);
    do_req("lbu100", 1'b0, 3'b100, 32'h0000_0100, 32'h0,         32'h0000_00FF, 1'b0, 2);
    do_req("lh102",  1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_8000, 1'b0, 2);
    do_req("lhu102", 1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h0000_8000, 1'b0, 2);

    // Byte store merges into the existing word.
    do_req("sb101",  1'b1, 3'b000, 32'h0000_0101, 32'hAAAA_AA12, 32'h0000_8000, 1'b0, 1);
    do_req("lw_sb",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h8000_12FF, 1'b0, 2);

    // Upper address bits alias onto the 128 KiB array.
    do_req("sw_alias", 1'b1, 3'b010, 32'h0002_0100, 32'hCAFE_BABE, 32'h8000_12FF, 1'b0, 1);
    do_req("lw_alias", 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hCAFE_BABE, 1'b0, 2);
    do_req("lb_be",    1'b0, 3'b000, 32'h0000_0100, 32'h0,         32'hFFFF_FFBE, 1'b0, 2);

    // Misaligned accesses.
    do_req("lw102_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0,
           TRAP ? 32'hFFFF_FFBE : 32'hCAFE_BABE, TRAP, 2);
    do_req("lh101_mis", 1'b0, 3'b001, 32'h0000_0101, 32'h0,
           TRAP ? 32'hFFFF_FFBE : 32'hFFFF_BABE, TRAP, 2);
    do_req("sh103_mis", 1'b1, 3'b001, 32'h0000_0103, 32'h0000_1234,
           TRAP ? 32'hFFFF_FFBE : 32'hFFFF_BABE, TRAP, 1);
    do_req("lw_after_sh", 1'b0, 3'b010, 32'h0000_0100, 32'h0,
           TRAP ? 32'hCAFE_BABE : 32'h1234_BABE, 1'b0, 2);

    // Unsupported funct3 codes.
    do_req("ld_f011", 1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 2);
    do_req("st_f011", 1'b1, 3'b011, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    do_req("lw_nowr", 1'b0, 3'b010, 32'h0000_0100, 32'h0,
           TRAP ? 32'hCAFE_BABE : 32'h1234_BABE, 1'b0, 2);
    do_req("ld_f111", 1'b0, 3'b111, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 2);

    // Reset while BUSY drops the pending response.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("busy_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstbusy_valid", {31'd0, resp_valid}, 32'd0);
    check("rstbusy_ready", {31'd0, req_ready}, 32'd1);
    check("rstbusy_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req("lw_post_rst", 1'b0, 3'b010, 32'h0000_0100, 32'h0,
           TRAP ? 32'hCAFE_BABE : 32'h1234_BABE, 1'b0, 2);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
